// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: captures a WIDTH-bit word under a valid/ready
// handshake and emits it one bit per cycle, with back-to-back frames allowed.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             dbg_shift_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   shreg_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               sout_q;
  logic               sout_valid_q;
  logic               frame_start_q;
  logic               done_q;
  logic               last_bit;
  logic               accept;
  logic               first_bit_d;
  logic               next_bit_d;

  // Handshake: a word on d is taken at a rising edge where load_valid and
  // load_ready are both high; load_ready is high when idle or on the last bit,
  // so a new frame can follow the previous one with no gap.
  always_comb begin
    last_bit    = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
    load_ready  = (state_q == IDLE) || last_bit;
    accept      = load_valid && load_ready;
    first_bit_d = MSB_FIRST ? d[WIDTH-1] : d[0];
    next_bit_d  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
    shreg_d     = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // cnt_q counts the bits still owed, including the one currently on sout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else if (accept) begin
      state_q       <= SHIFT;
      shreg_q       <= d;
      cnt_q         <= CNT_W'(WIDTH);
      sout_q        <= first_bit_d;
      sout_valid_q  <= 1'b1;
      frame_start_q <= 1'b1;
      done_q        <= 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_q       <= IDLE;
        shreg_q       <= '0;
        cnt_q         <= '0;
        sout_q        <= 1'b0;
        sout_valid_q  <= 1'b0;
        frame_start_q <= 1'b0;
        done_q        <= 1'b0;
      end else begin
        shreg_q       <= shreg_d;
        cnt_q         <= cnt_q - CNT_W'(1);
        sout_q        <= next_bit_d;
        sout_valid_q  <= 1'b1;
        frame_start_q <= 1'b0;
        done_q        <= (cnt_q == CNT_W'(2));
      end
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign dbg_shift_o = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4-bit MSB-first, 4-bit LSB-first,
// 2-bit MSB-first) share one stimulus stream and are tracked by a bit-count model.
module tb_piso_serializer;

  localparam int NI = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d     = 4'd0;
  logic       lv    = 1'b0;

  logic sout_w [NI];
  logic valid_w[NI];
  logic fs_w   [NI];
  logic done_w [NI];
  logic rdy_w  [NI];
  logic dbg_w  [NI];

  int checks = 0;
  int errors = 0;
  int fs_done_both = 0;

  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst_n), .d(d), .load_valid(lv), .load_ready(rdy_w[0]),
    .sout(sout_w[0]), .sout_valid(valid_w[0]), .frame_start(fs_w[0]),
    .done(done_w[0]), .dbg_shift_o(dbg_w[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst_n), .d(d), .load_valid(lv), .load_ready(rdy_w[1]),
    .sout(sout_w[1]), .sout_valid(valid_w[1]), .frame_start(fs_w[1]),
    .done(done_w[1]), .dbg_shift_o(dbg_w[1]));

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
    .clk(clk), .rst(rst_n), .d(d[1:0]), .load_valid(lv), .load_ready(rdy_w[2]),
    .sout(sout_w[2]), .sout_valid(valid_w[2]), .frame_start(fs_w[2]),
    .done(done_w[2]), .dbg_shift_o(dbg_w[2]));

  // ---------------- reference model ----------------
  // rem = bits of the current word still to appear on sout (incl. the present one).
  int          wid [NI] = '{4, 4, 2};
  bit          msbf[NI] = '{1'b1, 1'b0, 1'b1};
  int          rem [NI] = '{0, 0, 0};
  logic [31:0] word[NI] = '{32'd0, 32'd0, 32'd0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) rem[i] = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        automatic bit rdy = (rem[i] <= 1);
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        if (lv && rdy) begin
          word[i] = {28'd0, d} & ((32'd1 << wid[i]) - 32'd1);
          rem[i]  = wid[i];
        end
      end
    end
  end

  function automatic logic m_sout(input int i);
    int idx;
    if (rem[i] == 0) return 1'b0;
    idx = msbf[i] ? (rem[i] - 1) : (wid[i] - rem[i]);
    return word[i][idx];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_bit(input string nm, input int inst, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0b expected %0b", nm, inst, $time, got, exp);
    end
  endtask

  task automatic check_lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got 'b%0b expected 'b%0b", nm, $time, got, exp);
    end
  endtask

  task automatic check_word(input string nm, input logic [3:0] got);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      check_lit({nm, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_lit(nm, {28'd0, got}, {28'd0, exp});
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check_bit("sout_valid", i, valid_w[i], rem[i] > 0);
      check_bit("sout", i, sout_w[i], m_sout(i));
      check_bit("frame_start", i, fs_w[i], (rem[i] > 0) && (rem[i] == wid[i]));
      check_bit("done", i, done_w[i], rem[i] == 1);
      check_bit("load_ready", i, rdy_w[i], rem[i] <= 1);
      if (fs_w[i] && done_w[i]) fs_done_both++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    lv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Samples n consecutive cycles at negedge; first sampled cycle lands in the MSB.
  // If drop_at >= 0, load_valid is released just after the edge ending that cycle.
  task automatic capture(input int n, input int drop_at,
                         output logic [8:0] s0, output logic [8:0] s1,
                         output logic [8:0] vd, output logic [8:0] fs,
                         output logic [8:0] dn);
    s0 = '0; s1 = '0; vd = '0; fs = '0; dn = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s0 = {s0[7:0], sout_w[0]};
      s1 = {s1[7:0], sout_w[1]};
      vd = {vd[7:0], valid_w[0]};
      fs = {fs[7:0], fs_w[0]};
      dn = {dn[7:0], done_w[0]};
      if (k == drop_at) begin
        @(posedge clk);
        #1 lv = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] s0, s1, vd, fs, dn;

  initial begin
    // reset state, asynchronous
    #1;
    check_lit("rst_sout_valid", {31'd0, valid_w[0]}, 32'd0);
    check_lit("rst_sout", {31'd0, sout_w[0]}, 32'd0);
    check_lit("rst_load_ready", {31'd0, rdy_w[0]}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // idle with load_valid low
    lv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_lit("idle_sout_valid", {31'd0, valid_w[0]}, 32'd0);
      check_lit("idle_sout", {31'd0, sout_w[0]}, 32'd0);
      check_lit("idle_load_ready", {31'd0, rdy_w[0]}, 32'd1);
    end

    // single frame 1101, both bit orders
    @(posedge clk);
    #1 d = 4'b1101; lv = 1'b1;
    @(posedge clk);
    #1 lv = 1'b0; d = 4'($urandom_range(0, 15));
    capture(5, -1, s0, s1, vd, fs, dn);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1011);
    check_word("single_msb_bits", s0[4:1]);
    check_word("single_lsb_bits", s1[4:1]);
    check_lit("single_valid", {23'd0, vd}, 32'b11110);
    check_lit("single_frame_start", {23'd0, fs}, 32'b10000);
    check_lit("single_done", {23'd0, dn}, 32'b00010);
    idle(4);

    // back-to-back 1101 then 0110 with load_valid held
    @(posedge clk);
    #1 d = 4'b1101; lv = 1'b1;
    @(posedge clk);
    #1 d = 4'b0110;
    capture(9, 3, s0, s1, vd, fs, dn);
    check_lit("b2b_msb_bits", {23'd0, s0}, 32'b110101100);
    check_lit("b2b_lsb_bits", {23'd0, s1}, 32'b101101100);
    check_lit("b2b_valid", {23'd0, vd}, 32'b111111110);
    check_lit("b2b_frame_start", {23'd0, fs}, 32'b100010000);
    check_lit("b2b_done", {23'd0, dn}, 32'b000100010);
    idle(4);

    // word offered mid-frame must wait for the last bit
    @(posedge clk);
    #1 d = 4'b1101; lv = 1'b1;
    @(posedge clk);
    #1 lv = 1'b0;
    @(posedge clk);
    #1 d = 4'b0011; lv = 1'b1;
    capture(8, 2, s0, s1, vd, fs, dn);
    check_lit("busy_msb_bits", {24'd0, s0[7:0]}, 32'b10100110);
    check_lit("busy_valid", {24'd0, vd[7:0]}, 32'b11111110);
    check_lit("busy_frame_start", {24'd0, fs[7:0]}, 32'b00010000);
    check_lit("busy_done", {24'd0, dn[7:0]}, 32'b00100010);
    idle(4);

    // reset asserted between edges mid-frame
    @(posedge clk);
    #1 d = 4'b1101; lv = 1'b1;
    @(posedge clk);
    #1 lv = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_lit("midrst_outputs", {28'd0, sout_w[0], valid_w[0], fs_w[0], done_w[0]}, 32'd0);
    check_lit("midrst_load_ready", {31'd0, rdy_w[0]}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_lit("postrst_sout_valid", {31'd0, valid_w[0]}, 32'd0);
      check_lit("postrst_load_ready", {31'd0, rdy_w[0]}, 32'd1);
    end

    // randomized traffic with occasional reset pulses
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 d = 4'($urandom_range(0, 15));
      lv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    idle(6);

    check_lit("w2_frame_start_and_done_together", fs_done_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 transmitted first, 0 = bit 0 first.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port d  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port load_valid  input  1  d holds a word to be captured.
REQ-007 SHALL provide port load_ready  output  1  block can capture d this cycle.
REQ-008 SHALL provide port sout  output  1  serial data bit.
REQ-009 SHALL provide port sout_valid  output  1  sout carries a valid bit this cycle.
REQ-010 SHALL provide port frame_start  output  1  sout carries the first bit of a word.
REQ-011 SHALL provide port done  output  1  sout carries the last bit of a word.

Function
REQ-012 SHALL implement two states: IDLE (no word in flight) and SHIFT (word being transmitted).
REQ-013 SHALL assert load_ready combinationally when state is IDLE, or when state is SHIFT and the bit counter equals 1 (last bit).
REQ-014 SHALL accept a word only on a rising edge with load_valid=1 and load_ready=1; d is sampled into an internal WIDTH-bit shift register at that edge.
REQ-015 SHALL, on acceptance, load the bit counter with WIDTH and enter SHIFT; counter width = clog2(WIDTH+1).
REQ-016 SHALL present the first bit on sout, with sout_valid=1 and frame_start=1, in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-017 SHALL present one new bit per cycle for WIDTH consecutive cycles in the order set by MSB_FIRST, decrementing the counter each edge.
REQ-018 SHALL assert done for exactly the one cycle in which the last bit is on sout.
REQ-019 SHALL, at the edge ending the last bit with no acceptance, return to IDLE with sout_valid=0.
REQ-020 SHALL, when a new word is accepted at the edge ending the last bit, stay in SHIFT and present the new word's first bit in the next cycle with no gap (back-to-back frames).
REQ-021 SHALL ignore changes on d and load_valid while load_ready=0; an unaccepted word is never partially captured.
REQ-022 SHALL drive sout=0, frame_start=0 and done=0 whenever sout_valid=0.
REQ-023 SHALL, when WIDTH=2, assert frame_start and done in separate cycles (never both together).

Reset
REQ-024 SHALL, while rst=0, force state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, frame_start=0, done=0 immediately, independent of clk.
REQ-025 SHALL, when rst asserts mid-frame, discard the in-flight word; no remaining bits are emitted after release.
REQ-026 SHALL drive load_ready=1 during and after reset (state IDLE); the first acceptance occurs on the first rising edge with rst=1 and load_valid=1.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1, d=4'b1101 accepted at edge 0 -> sout 1,1,0,1 in cycles 1-4; frame_start in cycle 1 only; done in cycle 4 only; sout_valid=0 in cycle 5.
REQ-028 WIDTH=4, MSB_FIRST=0, d=4'b1101 -> sout 1,0,1,1 in cycles 1-4.
REQ-029 Back-to-back: 4'b1101 then 4'b0110 (load_valid held, second word accepted when load_ready rises in cycle 4) -> 8 contiguous valid bits 1,1,0,1,0,1,1,0; frame_start in cycles 1 and 5; done in cycles 4 and 8.
REQ-030 load_valid=1 with d=4'b0011 during cycle 2 of a 4'b1101 frame -> word not accepted; sout stays 1,1,0,1; 4'b0011 accepted only at the end of cycle 4.
REQ-031 rst=0 asserted between edges in cycle 2 of a frame -> all outputs 0 within the same cycle; after release sout_valid stays 0 until a new acceptance; load_ready=1.
REQ-032 Idle with load_valid=0 for 10 cycles -> sout_valid=0, sout=0, load_ready=1 throughout.
